// File: rtl/replay_peek_checker.sv
// Output checker for the replay harness: it queues expected records and compares DUT strobes against the queue head under a mask.
// The fail_* capture registers are built only when REPLAY_CHECK_CAPTURE_EN is defined; otherwise those outputs are tied to 0.
module replay_peek_checker #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8,
  parameter int CYCLE_W = 64,
  parameter int MAX_ERR = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exp_valid,
  output logic               exp_ready,
  input  logic [DATA_W-1:0]  exp_data,
  input  logic [DATA_W-1:0]  exp_mask,
  input  logic               exp_last,
  input  logic               dut_valid,
  input  logic [DATA_W-1:0]  dut_data,
  output logic               mismatch,
  output logic               underflow,
  output logic [15:0]        err_count,
  output logic [CYCLE_W-1:0] cycles,
  output logic [CYCLE_W-1:0] fail_cycle,
  output logic [DATA_W-1:0]  fail_data,
  output logic [DATA_W-1:0]  fail_expect,
  output logic               done,
  output logic               pass
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] MAX_ERR_C = 16'(MAX_ERR);

  typedef enum logic {RUN, DONE} state_t;
  state_t state;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DATA_W-1:0] mem_mask [DEPTH];
  logic [DEPTH-1:0]  mem_last;
  logic [AW:0]       wr_ptr, rd_ptr;

  logic              full, empty, push, pop, cmp, err, finish;
  logic [DATA_W-1:0] head_data, head_mask;
  logic              head_last;
  logic [15:0]       err_next;

  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Held low during reset so the harness never pushes into a clearing FIFO.
    exp_ready = !full && (state == RUN) && !reset;
    push      = exp_valid && exp_ready;
    head_data = mem_data[rd_ptr[AW-1:0]];
    head_mask = mem_mask[rd_ptr[AW-1:0]];
    head_last = mem_last[rd_ptr[AW-1:0]];
    cmp       = dut_valid && (state == RUN);
    pop       = cmp && !empty;
    err       = cmp && (empty || (((dut_data ^ head_data) & head_mask) != '0));
    err_next  = (err && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    finish    = (pop && head_last) || (err && (err_next == MAX_ERR_C));
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= exp_data;
      mem_mask[wr_ptr[AW-1:0]] <= exp_mask;
      mem_last[wr_ptr[AW-1:0]] <= exp_last;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mismatch  <= 1'b0;
      underflow <= 1'b0;
      err_count <= '0;
      cycles    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      mismatch  <= err;
      err_count <= err_next;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (cmp && empty) underflow <= 1'b1;
      case (state)
        RUN: begin
          if (finish) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end else begin
            cycles <= cycles + CYCLE_W'(1);
          end
        end
        DONE: state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

`ifdef REPLAY_CHECK_CAPTURE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail_cycle  <= '0;
      fail_data   <= '0;
      fail_expect <= '0;
    end else if (err && (err_count == 16'd0)) begin
      fail_cycle  <= cycles;
      fail_data   <= dut_data;
      fail_expect <= empty ? '0 : head_data;
    end
  end
`else
  assign fail_cycle  = '0;
  assign fail_data   = '0;
  assign fail_expect = '0;
`endif

endmodule
